// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the 4:1 mux channel scanner.
package mux_scan_pkg;

  localparam int NUM_CH = 4;

  // Channel index doubles as the {S1,S0} select value.
  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    logic    last;  // no enabled channel above cur
    ch_idx_t ch;    // next higher enabled channel (cur when last)
  } next_ch_t;

  // Next higher enabled channel after cur, plus a flag when cur is the last one.
  function automatic next_ch_t next_enabled(input logic [NUM_CH-1:0] mask,
                                            input ch_idx_t cur);
    next_ch_t r;
    r.last = 1'b1;
    r.ch   = cur;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((i > int'(cur)) && mask[i]) begin
        r.last = 1'b0;
        r.ch   = ch_idx_t'(i);
      end
    end
    return r;
  endfunction

  // Lowest enabled channel; 0 when the mask is empty.
  function automatic ch_idx_t first_enabled(input logic [NUM_CH-1:0] mask);
    ch_idx_t r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) r = ch_idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_dwell_counter.sv
// Settle-time counter: counts while enabled, flags terminal count at DWELL-2.
module mux_dwell_counter #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Clear has priority so every settle window starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_en)   r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == CNT_W'(DWELL - 2));

endmodule

// File: rtl/mux_channel_scanner.sv
// Round-robin select sequencer for a 4:1 mux: dwell, sample Y, emit one frame per scan.
// Handshake: frame/frame_valid are held stable while frame_valid=1; a transfer
// happens at a rising edge where frame_valid & frame_ready; ready alone does nothing.
module mux_channel_scanner
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [3:0]   ch_mask,
  output logic         S0,
  output logic         S1,
  input  logic         Y_in,
  output logic [3:0]   frame,
  output logic         frame_valid,
  input  logic         frame_ready,
  output state_t       dbg_state
);

  state_t     r_state, w_state;
  ch_idx_t    r_sel, w_sel;
  logic [3:0] r_mask, w_mask;
  logic [3:0] r_shadow, w_shadow;
  logic [3:0] r_frame, w_frame;
  logic       r_valid, w_valid;
  logic       w_tc;
  logic       w_start;
  next_ch_t   w_next;

  // Counter runs only while settling and sits at zero otherwise, so every
  // entry into SETTLE sees a fresh count.
  mux_dwell_counter #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (r_state != SETTLE),
    .i_en  (r_state == SETTLE),
    .o_tc  (w_tc)
  );

  assign w_start = en && (ch_mask != 4'b0000);
  assign w_next  = next_enabled(r_mask, r_sel);

  // Next-state and next-register values; everything defaults to hold.
  always_comb begin
    w_state  = r_state;
    w_sel    = r_sel;
    w_mask   = r_mask;
    w_shadow = r_shadow;
    w_frame  = r_frame;
    w_valid  = r_valid;
    unique case (r_state)
      IDLE: begin
        w_sel = '0;
        if (w_start) begin
          w_mask   = ch_mask;
          w_sel    = first_enabled(ch_mask);
          w_shadow = '0;
          w_state  = SETTLE;
        end
      end
      SETTLE: begin
        if (!en) begin
          w_sel   = '0;
          w_state = IDLE;
        end else if (w_tc) begin
          w_state = SAMPLE;
        end
      end
      SAMPLE: begin
        if (!en) begin
          w_sel   = '0;
          w_state = IDLE;
        end else begin
          w_shadow[r_sel] = Y_in;
          if (w_next.last) begin
            w_frame = w_shadow & r_mask;
            w_valid = 1'b1;
            w_state = HOLD;
          end else begin
            w_sel   = w_next.ch;
            w_state = SETTLE;
          end
        end
      end
      HOLD: begin
        // en is deliberately ignored here: the pending frame must be taken first.
        if (frame_ready) begin
          w_valid = 1'b0;
          if (w_start) begin
            w_mask   = ch_mask;
            w_sel    = first_enabled(ch_mask);
            w_shadow = '0;
            w_state  = SETTLE;
          end else begin
            w_sel   = '0;
            w_state = IDLE;
          end
        end
      end
      default: begin
        w_sel   = '0;
        w_state = IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_mask   <= '0;
      r_shadow <= '0;
      r_frame  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_sel    <= w_sel;
      r_mask   <= w_mask;
      r_shadow <= w_shadow;
      r_frame  <= w_frame;
      r_valid  <= w_valid;
    end
  end

  assign S1          = r_sel[1];
  assign S0          = r_sel[0];
  assign frame       = r_frame;
  assign frame_valid = r_valid;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Bench for mux_channel_scanner: DWELL=4 and DWELL=2 instances share stimulus;
// a slot-timing model predicts selects/frames every cycle, plus literal checks.
module tb_mux_channel_scanner;
  import mux_scan_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en = 1'b0;
  logic [3:0] ch_mask = 4'b0000;
  logic       frame_ready = 1'b0;
  logic [3:0] ymux = 4'b0000;  // value each mux input presents: bit i = channel i

  logic       d_s0 [2];
  logic       d_s1 [2];
  logic       d_y [2];
  logic [3:0] d_frame [2];
  logic       d_valid [2];
  state_t     d_state [2];

  assign d_y[0] = ymux[{d_s1[0], d_s0[0]}];
  assign d_y[1] = ymux[{d_s1[1], d_s0[1]}];

  mux_channel_scanner #(.DWELL(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask),
    .S0(d_s0[0]), .S1(d_s1[0]), .Y_in(d_y[0]),
    .frame(d_frame[0]), .frame_valid(d_valid[0]), .frame_ready(frame_ready),
    .dbg_state(d_state[0])
  );

  mux_channel_scanner #(.DWELL(2), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask),
    .S0(d_s0[1]), .S1(d_s1[1]), .Y_in(d_y[1]),
    .frame(d_frame[1]), .frame_valid(d_valid[1]), .frame_ready(frame_ready),
    .dbg_state(d_state[1])
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // A scan is a list of enabled channels; slot j owns edges j*DWELL..(j+1)*DWELL-1
  // after the start edge, and Y of slot j is taken at edge (j+1)*DWELL.
  int         dw [2] = '{4, 2};
  logic       m_scan [2];
  logic       m_valid [2];
  int         m_t [2];
  int         m_n [2];
  int         m_ch [2][4];
  logic [3:0] m_lmask [2];
  logic [3:0] m_acc [2];
  logic [3:0] m_frame [2];
  logic [1:0] m_sel [2];

  task automatic m_reset(input int i);
    m_scan[i] = 1'b0; m_valid[i] = 1'b0; m_t[i] = 0; m_n[i] = 0;
    m_lmask[i] = '0; m_acc[i] = '0; m_frame[i] = '0; m_sel[i] = '0;
  endtask

  task automatic m_start(input int i);
    m_lmask[i] = ch_mask;
    m_n[i] = 0;
    for (int c = 0; c < 4; c++) begin
      if (ch_mask[c]) begin
        m_ch[i][m_n[i]] = c;
        m_n[i]++;
      end
    end
    m_t[i] = 0;
    m_acc[i] = '0;
    m_sel[i] = 2'(m_ch[i][0]);
    m_scan[i] = 1'b1;
  endtask

  task automatic m_step(input int i);
    int j;
    int c;
    if (m_valid[i]) begin
      if (frame_ready) begin
        m_valid[i] = 1'b0;
        if (en && ch_mask != 4'b0000) m_start(i);
        else m_sel[i] = '0;
      end
    end else if (m_scan[i]) begin
      if (!en) begin
        m_scan[i] = 1'b0;
        m_sel[i] = '0;
      end else begin
        m_t[i]++;
        if (m_t[i] % dw[i] == 0) begin
          j = m_t[i] / dw[i];
          c = m_ch[i][j-1];
          m_acc[i][c] = ymux[c];
          if (j == m_n[i]) begin
            m_frame[i] = m_acc[i] & m_lmask[i];
            m_valid[i] = 1'b1;
            m_scan[i] = 1'b0;
          end else begin
            m_sel[i] = 2'(m_ch[i][j]);
          end
        end
      end
    end else begin
      if (en && ch_mask != 4'b0000) m_start(i);
      else m_sel[i] = '0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) m_reset(i);
      else m_step(i);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("sel_d%0d", dw[i]), {30'd0, d_s1[i], d_s0[i]}, {30'd0, m_sel[i]});
        chk($sformatf("valid_d%0d", dw[i]), {31'd0, d_valid[i]}, {31'd0, m_valid[i]});
        chk($sformatf("frame_d%0d", dw[i]), {28'd0, d_frame[i]}, {28'd0, m_frame[i]});
      end
    end
  end

  // ---------------- driver helpers ----------------
  // Counts rising edges until instance i shows frame_valid; also records selects seen.
  task automatic wait_valid(input int i, output int lat, output logic [3:0] seen,
                            output logic [3:0] frm);
    logic got;
    got = 1'b0; lat = 0; seen = '0; frm = '0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen[{d_s1[i], d_s0[i]}] = 1'b1;
      if (d_valid[i]) begin
        got = 1'b1;
        frm = d_frame[i];
      end
    end
    chk($sformatf("valid_within_budget_d%0d", dw[i]), {31'd0, got}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_sel"}, {30'd0, d_s1[i], d_s0[i]}, 32'd0);
      chk({tag, "_valid"}, {31'd0, d_valid[i]}, 32'd0);
      chk({tag, "_frame"}, {28'd0, d_frame[i]}, 32'd0);
      chk({tag, "_state"}, {30'd0, d_state[i]}, {30'd0, IDLE});
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int l0, l1;
    logic [3:0] s0v, s1v, f0, f1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    #2 rst_n = 1'b1;

    // Full mask, A=1 B=0 C=1 D=1, ready held high.
    @(negedge clk);
    ymux = 4'b1101; ch_mask = 4'b1111; frame_ready = 1'b1; en = 1'b1;
    fork
      wait_valid(0, l0, s0v, f0);
      wait_valid(1, l1, s1v, f1);
    join
    chk("t1_latency_d4", l0, 32'd17);
    chk("t1_latency_d2", l1, 32'd9);
    chk("t1_frame_d4", {28'd0, f0}, 32'hD);
    chk("t1_frame_d2", {28'd0, f1}, 32'hD);
    chk("t1_sels_seen_d4", {28'd0, s0v}, 32'hF);
    chk("t1_hold_sel_d4", {30'd0, d_s1[0], d_s0[0]}, 32'd3);
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_idle_after_take", {31'd0, d_valid[0]}, 32'd0);

    // Sparse mask A,C with mask change mid-frame.
    ymux = 4'b1111; ch_mask = 4'b0101; en = 1'b1;
    fork
      begin repeat (3) @(negedge clk); ch_mask = 4'b1111; end
      wait_valid(0, l0, s0v, f0);
    join
    chk("t2_latency", l0, 32'd9);
    chk("t2_frame", {28'd0, f0}, 32'h5);
    chk("t2_sels_seen", {28'd0, s0v}, 32'h5);
    en = 1'b0;
    repeat (3) @(negedge clk);

    // Backpressure for 20 cycles.
    frame_ready = 1'b0; ch_mask = 4'b1111; ymux = 4'b0110; en = 1'b1;
    wait_valid(0, l0, s0v, f0);
    chk("t3_latency", l0, 32'd17);
    chk("t3_frame", {28'd0, f0}, 32'h6);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t3_stall_valid", {31'd0, d_valid[0]}, 32'd1);
      chk("t3_stall_frame", {28'd0, d_frame[0]}, 32'h6);
      chk("t3_stall_sel", {30'd0, d_s1[0], d_s0[0]}, 32'd3);
    end
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk("t3_valid_drop", {31'd0, d_valid[0]}, 32'd0);
    chk("t3_restart_sel", {30'd0, d_s1[0], d_s0[0]}, 32'd0);
    chk("t3_restart_state", {30'd0, d_state[0]}, {30'd0, SETTLE});

    // Drop en while settling on channel C.
    repeat (9) @(negedge clk);
    chk("t4_on_c", {30'd0, d_s1[0], d_s0[0]}, 32'd2);
    chk("t4_on_c_state", {30'd0, d_state[0]}, {30'd0, SETTLE});
    en = 1'b0;
    @(negedge clk);
    chk("t4_sel", {30'd0, d_s1[0], d_s0[0]}, 32'd0);
    chk("t4_valid", {31'd0, d_valid[0]}, 32'd0);
    chk("t4_frame_kept", {28'd0, d_frame[0]}, 32'h6);
    chk("t4_state", {30'd0, d_state[0]}, {30'd0, IDLE});
    repeat (2) @(negedge clk);

    // Reset while holding a frame.
    en = 1'b1;
    wait_valid(0, l0, s0v, f0);
    chk("t5_latency", l0, 32'd17);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_in_hold");
    @(negedge clk);
    #2 rst_n = 1'b1;
    // Reset while settling.
    repeat (3) @(negedge clk);
    chk("t5_settle_state", {30'd0, d_state[0]}, {30'd0, SETTLE});
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_in_settle");
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_valid(0, l0, s0v, f0);
    chk("t5_restart_latency", l0, 32'd17);
    chk("t5_restart_frame", {28'd0, f0}, 32'h6);
    en = 1'b0; frame_ready = 1'b1;
    repeat (3) @(negedge clk);
    frame_ready = 1'b0;

    // Empty mask never starts a scan.
    ch_mask = 4'b0000; en = 1'b1;
    repeat (40) @(negedge clk);
    chk("t6_state", {30'd0, d_state[0]}, {30'd0, IDLE});
    chk("t6_valid", {31'd0, d_valid[1]}, 32'd0);

    // Single channel C, continuous frames.
    ymux = 4'b0100; ch_mask = 4'b0100; frame_ready = 1'b1;
    wait_valid(0, l0, s0v, f0);
    chk("t7_latency", l0, 32'd5);
    chk("t7_frame", {28'd0, f0}, 32'h4);
    chk("t7_sels_seen", {28'd0, s0v}, 32'h4);
    repeat (30) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
